// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into 32-bit words and writes them to instruction memory.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);

   localparam int MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [7:0]  len_lo;
   logic [15:0] word_cnt;
   logic [15:0] index;
   logic [1:0]  byte_idx;
   logic [31:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   logic        xfer;
   logic [15:0] new_count;
   logic        count_ok;
   logic        last_word;

   assign xfer      = byte_valid & byte_ready;
   assign new_count = {byte_data, len_lo};
   assign count_ok  = (new_count != 16'd0) && (int'(new_count) <= MAX_WORDS);
   assign last_word = (index + 16'd1) == word_cnt;

   // NOTE: every output is a register updated together with the state it belongs to,
   // so each branch sets the outputs that must hold in the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         len_lo     <= '0;
         word_cnt   <= '0;
         index      <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_hold  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_LEN_LO;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  index      <= '0;
                  byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum        <= '0;
`endif
                  core_hold  <= 1'b1;
                  byte_ready <= 1'b1;
               end
            end

            S_LEN_LO: begin
               if (xfer) begin
                  len_lo <= byte_data;
                  state  <= S_LEN_HI;
               end
            end

            S_LEN_HI: begin
               if (xfer) begin
                  if (count_ok) begin
                     word_cnt <= new_count;
                     state    <= S_DATA;
                  end else begin
                     state      <= S_ERROR;
                     error      <= 1'b1;
                     byte_ready <= 1'b0;
                     core_hold  <= 1'b0;
                  end
               end
            end

            // Bytes shift in from the top, so after four the first byte sits in [7:0].
            S_DATA: begin
               if (xfer) begin
                  asm_word <= {byte_data, asm_word[31:8]};
                  byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum + byte_data;
`endif
                  if (byte_idx == 2'd3) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     mem_we     <= 1'b1;
                     mem_addr   <= ADDR_W'(BASE_ADDR + int'(index));
                     mem_wdata  <= {byte_data, asm_word[31:8]};
                  end
               end
            end

            S_WRITE: begin
               mem_we <= 1'b0;
               index  <= index + 16'd1;
               if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state      <= S_CHECK;
                  byte_ready <= 1'b1;
`else
                  state      <= S_DONE;
                  done       <= 1'b1;
                  core_hold  <= 1'b0;
`endif
               end else begin
                  state      <= S_DATA;
                  byte_ready <= 1'b1;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (xfer) begin
                  byte_ready <= 1'b0;
                  core_hold  <= 1'b0;
                  if (byte_data == sum) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state      <= S_IDLE;
               byte_ready <= 1'b0;
               mem_we     <= 1'b0;
               core_hold  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers queue expected writes, a negedge monitor checks them.
// Works with LOADER_CHECKSUM_EN defined or undefined.
module tb_imem_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              done;
   logic              error;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t        exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] tb_sum = 8'h00;

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   wr_t mon_e;
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
            check("wr_data", mem_wdata, mon_e.data);
         end
         check("ready_in_write", 32'(byte_ready), 32'd0);
      end
   end

   task automatic check_zero(input string name);
      check({name, "_ready"}, 32'(byte_ready), 32'd0);
      check({name, "_we"},    32'(mem_we),     32'd0);
      check({name, "_addr"},  32'(mem_addr),   32'd0);
      check({name, "_wdata"}, mem_wdata,       32'd0);
      check({name, "_hold"},  32'(core_hold),  32'd0);
      check({name, "_done"},  32'(done),       32'd0);
      check({name, "_error"}, 32'(error),      32'd0);
   endtask

   // Called just after a negedge; returns just after the negedge following the transfer.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         checks++;
         errors++;
         $display("FAIL byte_stall: got byte_ready=0 for 40 cycles expected 1");
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_data(input logic [7:0] b, input int gap);
      tb_sum = tb_sum + b;
      send_byte(b, gap);
   endtask

   task automatic send_word(input int addr, input logic [31:0] w, input int gap);
      exp_q.push_back(wr_t'{ADDR_W'(addr), w});
      for (int i = 0; i < 4; i++) send_data(w[8*i +: 8], gap);
   endtask

   task automatic send_len(input logic [15:0] n);
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
   endtask

   task automatic send_sum();
`ifdef LOADER_CHECKSUM_EN
      send_byte(tb_sum, 0);
`endif
   endtask

   task automatic do_start(input string name);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      tb_sum = 8'h00;
      check({name, "_start_hold"},  32'(core_hold),  32'd1);
      check({name, "_start_ready"}, 32'(byte_ready), 32'd1);
      check({name, "_start_done"},  32'(done),       32'd0);
      check({name, "_start_error"}, 32'(error),      32'd0);
   endtask

   task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
      int n;
      n = 0;
      while (core_hold && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_hold"},    32'(core_hold),    32'd0);
      check({name, "_done"},    32'(done),         32'(exp_done));
      check({name, "_error"},   32'(error),        32'(exp_err));
      check({name, "_ready"},   32'(byte_ready),   32'd0);
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("idle");

      // Two-word program
      do_start("t2w");
      send_len(16'd2);
      send_word(0, 32'h0000_0013, 0);
      send_word(1, 32'h0010_0093, 0);
      send_sum();
      wait_end("t2w", 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("done_sticky", 32'(done), 32'd1);

      // Single word DEADBEEF with literal checksum bytes
      do_start("tdb");
      send_len(16'd1);
      send_word(0, 32'hDEAD_BEEF, 0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h38, 0);
`endif
      wait_end("tdb", 1'b1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      do_start("tbad");
      send_len(16'd1);
      send_word(0, 32'hDEAD_BEEF, 0);
      send_byte(8'h39, 0);
      wait_end("tbad", 1'b0, 1'b1);
`endif

      // Start coinciding with a valid byte in DONE/ERROR: byte must not be consumed
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h05;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      tb_sum     = 8'h00;
      check("ss_hold",  32'(core_hold),  32'd1);
      check("ss_ready", 32'(byte_ready), 32'd1);
      send_len(16'd1);
      send_word(0, 32'hCAFE_0001, 0);
      send_sum();
      wait_end("ss", 1'b1, 1'b0);

      // Count limits
      do_start("tz");
      send_len(16'h0000);
      wait_end("tz", 1'b0, 1'b1);
      do_start("tov");
      send_len(16'h0401);
      wait_end("tov", 1'b0, 1'b1);
      do_start("tmax");
      send_len(16'h0400);
      check("max_error", 32'(error),      32'd0);
      check("max_hold",  32'(core_hold),  32'd1);
      check("max_ready", 32'(byte_ready), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("max_abort");

      // Valid toggling over a three-word load
      do_start("tgap");
      send_len(16'd3);
      send_word(0, 32'h0102_0304, 1);
      send_word(1, 32'hA5A5_5A5A, 1);
      send_word(2, 32'hFFFF_FFFF, 1);
      send_sum();
      wait_end("tgap", 1'b1, 1'b0);

      // Reset in the middle of a four-word load
      do_start("trst");
      send_len(16'd4);
      send_word(0, 32'h1111_1111, 0);
      for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
      check("rst_w0_written", 32'(exp_q.size()), 32'd0);
      send_data(8'h22, 0);
      send_data(8'h22, 0);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("after_rst");
      do_start("trst2");
      send_len(16'd1);
      send_word(0, 32'h7654_3210, 0);
      send_sum();
      wait_end("trst2", 1'b1, 1'b0);

      // Start pulse in the middle of word assembly is ignored
      do_start("tmid");
      send_len(16'd2);
      exp_q.push_back(wr_t'{ADDR_W'(0), 32'h4433_2211});
      send_data(8'h11, 0);
      send_data(8'h22, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mid_hold",  32'(core_hold),  32'd1);
      check("mid_ready", 32'(byte_ready), 32'd1);
      check("mid_done",  32'(done),       32'd0);
      check("mid_error", 32'(error),      32'd0);
      send_data(8'h33, 0);
      send_data(8'h44, 0);
      send_word(1, 32'h8877_6655, 0);
      send_sum();
      wait_end("tmid", 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-002 Parameter BASE_ADDR, default 0, first word address written.
REQ-003 CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  incoming load-stream byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  ADDR_W  word address for the write.
REQ-011 mem_wdata  output  32  instruction word for the write.
REQ-012 core_hold  output  1  high while loading; holds the CPU off instruction memory.
REQ-013 done  output  1  sticky: last load completed successfully.
REQ-014 error  output  1  sticky: last load aborted on a format or checksum fault.

Function
REQ-015 A byte transfers only on a cycle where byte_valid and byte_ready are both high.
REQ-016 Stream format: count low byte, count high byte (word count N, 16-bit little-endian), then N words of 4 bytes each, least significant byte first, then one checksum byte when LOADER_CHECKSUM_EN is defined.
REQ-017 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + start -> LEN_LO; this clears done, clears error, zeroes the word index and checksum, and sets core_hold.
REQ-019 LEN_LO -> LEN_HI on a transfer.
REQ-020 LEN_HI -> DATA on a transfer when 1 <= N <= 2**ADDR_W - BASE_ADDR.
REQ-021 LEN_HI -> ERROR on a transfer when N is 0 or exceeds that limit.
REQ-022 DATA assembles bytes 0..3 into the current word; after the 4th transfer it goes to WRITE.
REQ-023 WRITE lasts exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word.
REQ-024 WRITE then increments index; if index+1==N it goes to CHECK (checksum enabled) or DONE (disabled), otherwise to DATA.
REQ-025 Write latency: mem_we rises one cycle after the transfer of the 4th byte of a word.
REQ-026 byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK; it is 0 in IDLE, WRITE, DONE and ERROR.
REQ-027 mem_we is 0 in every state except WRITE.
REQ-028 mem_addr and mem_wdata are don't-care when mem_we=0, but mem_addr never exceeds 2**ADDR_W-1.
REQ-029 core_hold=1 in LEN_LO through CHECK and 0 in IDLE, DONE and ERROR.
REQ-030 done is set on entry to DONE; error is set on entry to ERROR; both hold until the next accepted start or reset.
REQ-031 start received in any state other than IDLE, DONE or ERROR is ignored.
REQ-032 A byte_valid gap of any length simply stalls the loader; there is no timeout.
REQ-033 A start coinciding with a transfer in DONE or ERROR is a start only; the byte is not accepted, since byte_ready is 0 in those states.

Reset
REQ-034 RST_N low asynchronously forces IDLE, index=0, checksum=0, assembly register=0.
REQ-035 RST_N low forces byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=0, done=0, error=0.
REQ-036 Reset during a load abandons it; words already written stay in memory, and neither done nor error is set.
REQ-037 Operation resumes on the first rising CLK edge after RST_N is released.

Configuration
REQ-038 Macro LOADER_CHECKSUM_EN defined: the loader keeps an 8-bit sum, modulo 256, of all data bytes.
REQ-039 With LOADER_CHECKSUM_EN, the CHECK state accepts one byte and goes to DONE if it equals the sum, otherwise to ERROR.
REQ-040 Macro LOADER_CHECKSUM_EN undefined: the CHECK state and sum logic are absent, and the last WRITE goes directly to DONE.

Verification
REQ-041 Checksum disabled: start, then bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr0=00000013 and addr1=00100093; done=1, core_hold=0.
REQ-042 Checksum enabled: stream 01 00 EF BE AD DE 38 -> addr0=DEADBEEF, done=1; the same stream with final byte 39 -> error=1, done=0.
REQ-043 Count 00 00, or count 01 04 with ADDR_W=10 -> ERROR after the 2nd byte, no mem_we, byte_ready=0.
REQ-044 byte_valid toggled 1-0-1 every cycle over a 3-word load -> the same three words are written, and byte_ready=0 during each WRITE cycle.
REQ-045 RST_N pulsed low after word 0 of a 4-word load -> all outputs 0 at once; a following start plus a full 1-word stream loads and sets done.
REQ-046 start pulsed mid-DATA -> ignored; word assembly and addresses are unaffected.
